// File: rtl/cycle_phase_timer.sv
// Two-level phase timer: a clk_freq-cycle prescaler produces unit ticks that
// count a period down, with pause, abort, restart and optional auto-reload.
module cycle_phase_timer #(
    parameter int FREQ_W   = 8,
    parameter int PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                pause,
    input  logic                reload_mode,
    input  logic [FREQ_W-1:0]   clk_freq,
    input  logic [PERIOD_W-1:0] timer_period,
    output logic                busy,
    output logic                paused,
    output logic                sec_tick,
    output logic                done,
    output logic                error,
    output logic [PERIOD_W-1:0] remaining
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                state;
    state_t                state_next;
    logic [FREQ_W-1:0]     prescaler;
    logic [FREQ_W-1:0]     freq_q;
    logic [PERIOD_W-1:0]   period_q;
    logic [PERIOD_W-1:0]   remaining_q;
    logic                  mode_q;
    logic                  sec_tick_q;
    logic                  done_q;
    logic                  error_q;

    logic start_valid;
    logic start_bad;
    logic advance;
    logic unit_end;
    logic expire;

    // A rejected start only raises error; the rest of the edge behaves as if start were low.
    assign start_valid = start && (clk_freq != '0) && (timer_period != '0);
    assign start_bad   = start && !start_valid && !abort;
    assign advance     = !abort && !start_valid && (state == RUN) && !pause;
    assign unit_end    = advance && (prescaler == freq_q - FREQ_W'(1));
    assign expire      = unit_end && (remaining_q == PERIOD_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else if (start_valid) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (pause) begin
                        state_next = HOLD;
                    end else if (expire && !mode_q) begin
                        state_next = IDLE;
                    end
                end
                HOLD: begin
                    if (!pause) begin
                        state_next = RUN;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler   <= '0;
            remaining_q <= '0;
            freq_q      <= '0;
            period_q    <= '0;
            mode_q      <= 1'b0;
            sec_tick_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            sec_tick_q <= unit_end;
            done_q     <= expire;
            error_q    <= start_bad;
            if (abort) begin
                prescaler   <= '0;
                remaining_q <= '0;
            end else if (start_valid) begin
                freq_q      <= clk_freq;
                period_q    <= timer_period;
                mode_q      <= reload_mode;
                prescaler   <= '0;
                remaining_q <= timer_period;
            end else if (advance) begin
                if (unit_end) begin
                    prescaler <= '0;
                    // Auto-reload starts the next phase on the expiry edge itself.
                    if (expire) begin
                        remaining_q <= mode_q ? period_q : '0;
                    end else begin
                        remaining_q <= remaining_q - PERIOD_W'(1);
                    end
                end else begin
                    prescaler <= prescaler + FREQ_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy      = 1'b0;
        paused    = 1'b0;
        sec_tick  = sec_tick_q;
        done      = done_q;
        error     = error_q;
        remaining = remaining_q;
        case (state)
            RUN:     busy = 1'b1;
            HOLD: begin
                busy   = 1'b1;
                paused = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cycle_phase_timer.sv
// Directed-vector bench for cycle_phase_timer; expected values are worked out
// by hand from the edge-numbered timeline, with the start edge as edge 0.
module tb_cycle_phase_timer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       pause;
    logic       reload_mode;
    logic [7:0] clk_freq;
    logic [7:0] timer_period;
    logic       busy;
    logic       paused;
    logic       sec_tick;
    logic       done;
    logic       error;
    logic [7:0] remaining;

    int vectors;
    int miscompares;
    int done_count;

    cycle_phase_timer #(.FREQ_W(8), .PERIOD_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .pause        (pause),
        .reload_mode  (reload_mode),
        .clk_freq     (clk_freq),
        .timer_period (timer_period),
        .busy         (busy),
        .paused       (paused),
        .sec_tick     (sec_tick),
        .done         (done),
        .error        (error),
        .remaining    (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, leaving the bench 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a start strobe for exactly one edge.
    task automatic applyStimulus(input logic [7:0] freq, input logic [7:0] period, input logic mode);
        clk_freq     = freq;
        timer_period = period;
        reload_mode  = mode;
        start        = 1'b1;
        tick(1);
        start        = 1'b0;
    endtask

    task automatic resetDut();
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reload_mode  = 1'b0;
        clk_freq     = '0;
        timer_period = '0;
        resetDut();

        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_paused", paused, 0);
        checkOutput("rst_remaining", remaining, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);

        // One-shot, freq 2, period 3: ticks after edges 2,4,6 and done after edge 6.
        applyStimulus(8'd2, 8'd3, 1'b0);
        checkOutput("os_e0_remaining", remaining, 3);
        checkOutput("os_e0_busy", busy, 1);
        tick(2);
        checkOutput("os_e2_tick", sec_tick, 1);
        checkOutput("os_e2_remaining", remaining, 2);
        tick(1);
        checkOutput("os_e3_tick", sec_tick, 0);
        tick(1);
        checkOutput("os_e4_remaining", remaining, 1);
        tick(1);
        checkOutput("os_e5_done", done, 0);
        tick(1);
        checkOutput("os_e6_done", done, 1);
        checkOutput("os_e6_tick", sec_tick, 1);
        checkOutput("os_e6_busy", busy, 0);
        checkOutput("os_e6_remaining", remaining, 0);
        tick(1);
        checkOutput("os_e7_done", done, 0);

        // Auto-reload: done after edges 6 and 12, abort lands on edge 14.
        resetDut();
        applyStimulus(8'd2, 8'd3, 1'b1);
        tick(6);
        checkOutput("ar_e6_done", done, 1);
        checkOutput("ar_e6_remaining", remaining, 3);
        checkOutput("ar_e6_busy", busy, 1);
        tick(6);
        checkOutput("ar_e12_done", done, 1);
        checkOutput("ar_e12_remaining", remaining, 3);
        tick(1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        checkOutput("ar_abort_busy", busy, 0);
        checkOutput("ar_abort_remaining", remaining, 0);
        checkOutput("ar_abort_tick", sec_tick, 0);
        checkOutput("ar_abort_done", done, 0);
        done_count = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (done) done_count++;
        end
        checkOutput("ar_no_done_after_abort", done_count, 0);

        // Pause over edges 3..10 with freq 4, period 2: done moves from edge 8 to 17.
        resetDut();
        applyStimulus(8'd4, 8'd2, 1'b0);
        tick(2);
        pause = 1'b1;
        tick(1);
        checkOutput("pz_e3_paused", paused, 1);
        checkOutput("pz_e3_remaining", remaining, 2);
        tick(7);
        checkOutput("pz_e10_paused", paused, 1);
        checkOutput("pz_e10_remaining", remaining, 2);
        pause = 1'b0;
        tick(1);
        checkOutput("pz_e11_paused", paused, 0);
        checkOutput("pz_e11_busy", busy, 1);
        tick(2);
        checkOutput("pz_e13_tick", sec_tick, 1);
        checkOutput("pz_e13_remaining", remaining, 1);
        tick(3);
        checkOutput("pz_e16_done", done, 0);
        tick(1);
        checkOutput("pz_e17_done", done, 1);

        // Illegal programming: from IDLE, then while running on a unit edge.
        resetDut();
        applyStimulus(8'd0, 8'd3, 1'b0);
        checkOutput("err_idle_error", error, 1);
        checkOutput("err_idle_busy", busy, 0);
        tick(1);
        checkOutput("err_idle_pulse_end", error, 0);
        applyStimulus(8'd2, 8'd3, 1'b0);
        tick(1);
        applyStimulus(8'd2, 8'd0, 1'b0);
        checkOutput("err_run_error", error, 1);
        checkOutput("err_run_remaining", remaining, 2);
        checkOutput("err_run_tick", sec_tick, 1);
        tick(4);
        checkOutput("err_run_done", done, 1);

        // Restart at edge 7 with period 2 (freq 3): done after edge 13.
        resetDut();
        applyStimulus(8'd3, 8'd5, 1'b0);
        tick(6);
        checkOutput("rs_e6_remaining", remaining, 3);
        applyStimulus(8'd3, 8'd2, 1'b0);
        checkOutput("rs_e7_remaining", remaining, 2);
        tick(5);
        checkOutput("rs_e12_done", done, 0);
        tick(1);
        checkOutput("rs_e13_done", done, 1);

        // Start on the expiry edge wins: no done, count restarts.
        resetDut();
        applyStimulus(8'd2, 8'd1, 1'b0);
        tick(1);
        applyStimulus(8'd2, 8'd1, 1'b0);
        checkOutput("se_done", done, 0);
        checkOutput("se_busy", busy, 1);
        checkOutput("se_remaining", remaining, 1);
        tick(2);
        checkOutput("se_next_done", done, 1);

        // Asynchronous reset between edges while sec_tick is high.
        resetDut();
        applyStimulus(8'd2, 8'd3, 1'b0);
        tick(2);
        checkOutput("ar_pre_tick", sec_tick, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_busy", busy, 0);
        checkOutput("async_remaining", remaining, 0);
        checkOutput("async_tick", sec_tick, 0);
        tick(2);
        reset = 1'b0;
        tick(1);
        checkOutput("post_rst_busy", busy, 0);
        checkOutput("post_rst_remaining", remaining, 0);
        checkOutput("post_rst_done", done, 0);
        checkOutput("post_rst_error", error, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
